// File: rtl/register_file_pkg.sv
// Shared constants and state encoding for the TinyCPU register file.
package register_file_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    typedef enum logic {
        RF_STATE_INIT,
        RF_STATE_READY
    } rf_state_t;

endpackage

// File: rtl/register_file.sv
// 32-entry, two-read/one-write register file with registered read data,
// write-to-read bypass and a post-reset clear sweep gating ready.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH  = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH  = REG_ADDR_WIDTH,
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_reg_0,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic                  ready
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    rf_state_t             state;
    logic [ADDR_WIDTH-1:0] clear_idx;
    logic                  wr_commit;
    logic [DATA_WIDTH-1:0] rd_next_0;
    logic [DATA_WIDTH-1:0] rd_next_1;

    // A write counts only in READY and only if it is not aimed at a read-only r0;
    // the same qualified strobe drives both storage and bypass.
    always_comb begin
        wr_commit = (state == RF_STATE_READY) && write_enable &&
                    !(ZERO_REG_RO && (write_address == '0));

        rd_next_0 = mem[read_reg_0];
        if (wr_commit && (write_address == read_reg_0))
            rd_next_0 = write_data;
        if (ZERO_REG_RO && (read_reg_0 == '0))
            rd_next_0 = '0;

        rd_next_1 = mem[read_reg_1];
        if (wr_commit && (write_address == read_reg_1))
            rd_next_1 = write_data;
        if (ZERO_REG_RO && (read_reg_1 == '0))
            rd_next_1 = '0;
    end

    // Storage has no reset; the INIT sweep clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state == RF_STATE_INIT)
            mem[clear_idx] <= '0;
        else if (wr_commit)
            mem[write_address] <= write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RF_STATE_INIT;
            clear_idx   <= '0;
            ready       <= 1'b0;
            read_data_0 <= '0;
            read_data_1 <= '0;
        end else if (state == RF_STATE_INIT) begin
            clear_idx   <= clear_idx + 1'b1;
            read_data_0 <= '0;
            read_data_1 <= '0;
            if (clear_idx == '1) begin
                state <= RF_STATE_READY;
                ready <= 1'b1;
            end
        end else begin
            read_data_0 <= rd_next_0;
            read_data_1 <= rd_next_1;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected outputs per
// cycle, a negedge monitor compares them against two DUTs (r0 writable / read-only).
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  write_address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic [4:0]  read_reg_0 = '0;
    logic [4:0]  read_reg_1 = '0;
    logic [31:0] read_data_0, read_data_1, read_data_0_z, read_data_1_z;
    logic        ready, ready_z;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_file dut (
        .clk(clk), .rst_n(rst_n),
        .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .read_data_0(read_data_0), .read_data_1(read_data_1), .ready(ready)
    );

    register_file #(.ZERO_REG_RO(1'b1)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .write_address(write_address), .write_data(write_data), .write_enable(write_enable),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .read_data_0(read_data_0_z), .read_data_1(read_data_1_z), .ready(ready_z)
    );

    // kind: 0 rd0, 1 rd1, 2 ready, 3 rd0 (r0 read-only), 4 rd1 (r0 read-only), 5 ready (r0 read-only)
    function automatic logic [31:0] actual(input int kind);
        case (kind)
            0:       return read_data_0;
            1:       return read_data_1;
            2:       return {31'b0, ready};
            3:       return read_data_0_z;
            4:       return read_data_1_z;
            default: return {31'b0, ready_z};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int due, input int kind, input logic [31:0] exp, input string name);
        sb.push_back('{due: due, kind: kind, exp: exp, name: name});
    endtask

    // Both instances must agree on these, whatever ZERO_REG_RO is.
    task automatic expect_both(input int due, input int port, input logic [31:0] exp, input string name);
        expect_at(due, port, exp, name);
        expect_at(due, port + 3, exp, {name, "_z"});
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].name, actual(sb[i].kind), sb[i].exp);
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", sb[i].name, sb[i].due, cyc);
                sb.delete(i);
            end
        end
    end

    initial begin
        int base;

        // Reset sweep with a write held active throughout INIT.
        write_enable  = 1'b1;
        write_address = 5'd3;
        write_data    = 32'hDEAD;
        read_reg_0    = 5'd3;
        read_reg_1    = 5'd0;
        step();
        step();
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_rd0", read_data_0, 32'd0);
        rst_n = 1'b1;
        base = cyc;
        expect_both(base + 16, 2, 32'd0, "init_ready_low");
        expect_both(base + 16, 0, 32'd0, "init_rd0_held");
        expect_both(base + 31, 2, 32'd0, "ready_not_early");
        expect_both(base + 32, 2, 32'd1, "ready_at_32");
        for (int i = 0; i < 32; i++) step();
        write_enable = 1'b0;
        expect_both(cyc + 1, 0, 32'd0, "r3_cleared");
        step();

        // Basic write then read; port 1 watches an untouched register.
        write_enable  = 1'b1;
        write_address = 5'd5;
        write_data    = 32'h12345678;
        read_reg_0    = 5'd3;
        read_reg_1    = 5'd3;
        step();
        write_enable = 1'b0;
        read_reg_0   = 5'd5;
        expect_both(cyc + 1, 0, 32'h12345678, "basic_rd0");
        expect_both(cyc + 1, 1, 32'd0, "basic_rd1");
        step();

        // Bypass on both ports.
        write_enable  = 1'b1;
        write_address = 5'd7;
        write_data    = 32'h11;
        step();
        write_data = 32'h22;
        read_reg_0 = 5'd7;
        read_reg_1 = 5'd7;
        expect_both(cyc + 1, 0, 32'h22, "bypass_rd0");
        expect_both(cyc + 1, 1, 32'h22, "bypass_rd1");
        step();
        write_enable = 1'b0;
        expect_both(cyc + 1, 0, 32'h22, "stored_rd0");
        step();

        // Register 0: writable in dut, read-only in dut_z.
        write_enable  = 1'b1;
        write_address = 5'd0;
        write_data    = 32'hFFFFFFFF;
        read_reg_0    = 5'd0;
        read_reg_1    = 5'd0;
        expect_at(cyc + 1, 0, 32'hFFFFFFFF, "r0_rw_bypass");
        expect_at(cyc + 1, 3, 32'd0, "r0_ro_bypass_rd0");
        expect_at(cyc + 1, 4, 32'd0, "r0_ro_bypass_rd1");
        step();
        write_enable = 1'b0;
        expect_at(cyc + 1, 1, 32'hFFFFFFFF, "r0_rw_later");
        expect_at(cyc + 1, 3, 32'd0, "r0_ro_later_rd0");
        expect_at(cyc + 1, 4, 32'd0, "r0_ro_later_rd1");
        step();

        // Full fill r_i = i*3, then read pairs (i, 31-i).
        read_reg_0   = 5'd31;
        read_reg_1   = 5'd31;
        write_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            write_address = 5'(i);
            write_data    = 32'(i * 3);
            if (i == 31) expect_both(cyc + 1, 0, 32'd93, "fill_bypass_r31");
            step();
        end
        write_enable = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg_0 = 5'(i);
            read_reg_1 = 5'(31 - i);
            if (i == 0) begin
                expect_at(cyc + 1, 0, 32'd0, "pair_rd0_r0");
                expect_at(cyc + 1, 3, 32'd0, "pair_rd0_r0_z");
            end else begin
                expect_both(cyc + 1, 0, 32'(i * 3), $sformatf("pair_rd0_r%0d", i));
            end
            if (i == 31) begin
                expect_at(cyc + 1, 1, 32'd0, "pair_rd1_r0");
                expect_at(cyc + 1, 4, 32'd0, "pair_rd1_r0_z");
            end else begin
                expect_both(cyc + 1, 1, 32'((31 - i) * 3), $sformatf("pair_rd1_r%0d", 31 - i));
            end
            step();
        end

        // Reset out of READY clears outputs asynchronously, then a mid-sweep reset.
        read_reg_0 = 5'd5;
        read_reg_1 = 5'd10;
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_ready_low", {31'b0, ready}, 32'd0);
        check("async_rd0_zero", read_data_0, 32'd0);
        check("async_rd1_zero", read_data_1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = cyc;
        expect_both(base + 31, 2, 32'd0, "midreset_not_early");
        expect_both(base + 32, 2, 32'd1, "midreset_ready_at_32");
        for (int i = 0; i < 32; i++) step();
        expect_both(cyc + 1, 0, 32'd0, "resweep_r5_cleared");
        expect_both(cyc + 1, 1, 32'd0, "resweep_r10_cleared");
        step();
        step();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
